// File: rtl/motion_update_broadcast_arbiter.sv
// Round-robin arbiter sharing one broadcast bus between NUM_REQ motion-update pipelines,
// sequencing IDLE/BROADCAST/DRAIN/GUARD/DONE. Optional watchdog: define MU_ARB_TIMEOUT_EN.
module motion_update_broadcast_arbiter #(
  parameter int DATA_WIDTH     = 32,
  parameter int CELL_ID_WIDTH  = 4,
  parameter int NUM_REQ        = 4,
  parameter int GUARD_CYCLES   = 3,
  parameter int COUNT_WIDTH    = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 in_start,
  input  logic [NUM_REQ-1:0]                   in_req_valid,
  input  logic [NUM_REQ*3*DATA_WIDTH-1:0]      in_req_data,
  input  logic [NUM_REQ*3*CELL_ID_WIDTH-1:0]   in_req_dst_cell,
  input  logic [NUM_REQ-1:0]                   in_req_done,
  output logic [NUM_REQ-1:0]                   out_req_ready,
  output logic                                 out_motion_update_enable,
  output logic [3*DATA_WIDTH-1:0]              out_data,
  output logic [3*CELL_ID_WIDTH-1:0]           out_data_dst_cell,
  output logic                                 out_data_valid,
  output logic                                 out_busy,
  output logic                                 out_done,
  output logic [COUNT_WIDTH-1:0]               out_beat_count
`ifdef MU_ARB_TIMEOUT_EN
  ,
  output logic                                 out_timeout
`endif
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int GW    = $clog2(GUARD_CYCLES + 1);
  localparam int BW    = 3 * DATA_WIDTH;
  localparam int CW    = 3 * CELL_ID_WIDTH;

  if (NUM_REQ < 2 || GUARD_CYCLES < 2 || TIMEOUT_CYCLES < 2) begin : g_bad_params
    $error("motion_update_broadcast_arbiter: NUM_REQ, GUARD_CYCLES and TIMEOUT_CYCLES must be >= 2");
  end

  typedef enum logic [2:0] {IDLE, BROADCAST, DRAIN, GUARD, DONE} state_t;

  state_t                 state_q, state_d;
  logic [PTR_W-1:0]       ptr_q;
  logic [NUM_REQ-1:0]     done_flags_q;
  logic [GW-1:0]          guard_cnt_q;
  logic [COUNT_WIDTH-1:0] beat_count_q;
  logic                   enable_q, busy_q, done_q;
  logic                   enable_d, busy_d, done_d;
  logic [NUM_REQ-1:0]     grant;
  logic [PTR_W-1:0]       grant_idx;
  logic [PTR_W:0]         cand;
  logic                   found;
  logic                   handshake;
  logic                   all_done;
  logic                   timeout_hit;
  logic [BW-1:0]          sel_data;
  logic [CW-1:0]          sel_dst;
  logic [BW-1:0]          data_p1;
  logic [CW-1:0]          dst_p1;
  logic                   vld_p1;

  function automatic logic [COUNT_WIDTH-1:0] sat_inc(input logic [COUNT_WIDTH-1:0] v);
    return (&v) ? v : v + COUNT_WIDTH'(1);
  endfunction

  // First valid requester at or after the pointer, wrapping modulo NUM_REQ.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = '0;
    if (state_q == BROADCAST) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        cand = {1'b0, ptr_q} + (PTR_W+1)'(k);
        if (cand >= (PTR_W+1)'(NUM_REQ)) cand = cand - (PTR_W+1)'(NUM_REQ);
        if (!found && in_req_valid[cand[PTR_W-1:0]]) begin
          found                   = 1'b1;
          grant_idx               = cand[PTR_W-1:0];
          grant[cand[PTR_W-1:0]]  = 1'b1;
        end
      end
    end
  end

  assign out_req_ready = grant;
  assign handshake     = |(grant & in_req_valid);
  assign all_done      = &(done_flags_q | in_req_done);

  always_comb begin
    sel_data = '0;
    sel_dst  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_data = in_req_data[i*BW +: BW];
        sel_dst  = in_req_dst_cell[i*CW +: CW];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (in_start) state_d = BROADCAST;
      BROADCAST: if ((all_done && !(|in_req_valid)) || timeout_hit) state_d = DRAIN;
      DRAIN:     state_d = GUARD;
      GUARD:     if (guard_cnt_q == GW'(GUARD_CYCLES - 1)) state_d = DONE;
      DONE:      state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_comb begin
    enable_d = (state_d == BROADCAST) || (state_d == DRAIN);
    busy_d   = (state_d != IDLE);
    done_d   = (state_d == DONE);
  end

  // Stage p1: registered control and the broadcast beat one cycle after its handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      ptr_q        <= '0;
      done_flags_q <= '0;
      guard_cnt_q  <= '0;
      beat_count_q <= '0;
      enable_q     <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      vld_p1       <= 1'b0;
      data_p1      <= '0;
      dst_p1       <= '0;
    end else begin
      state_q  <= state_d;
      enable_q <= enable_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      vld_p1   <= handshake;
      data_p1  <= handshake ? sel_data : '0;
      dst_p1   <= handshake ? sel_dst  : '0;
      guard_cnt_q <= (state_q == GUARD) ? guard_cnt_q + GW'(1) : '0;
      if (state_q == IDLE && in_start) begin
        done_flags_q <= '0;
        beat_count_q <= '0;
      end else if (state_q == BROADCAST) begin
        done_flags_q <= done_flags_q | in_req_done;
        if (handshake) begin
          ptr_q        <= (grant_idx == PTR_W'(NUM_REQ - 1)) ? '0 : grant_idx + PTR_W'(1);
          beat_count_q <= sat_inc(beat_count_q);
        end
      end
    end
  end

`ifdef MU_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] idle_cnt_q;
  logic          timeout_q;

  // idle_cnt_q holds the number of cycles elapsed since the last handshake (or pass start).
  assign timeout_hit = (state_q == BROADCAST) && !handshake &&
                       (idle_cnt_q == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      idle_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else if (state_q == IDLE && in_start) begin
      idle_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else if (state_q == BROADCAST) begin
      idle_cnt_q <= handshake ? TW'(1) : idle_cnt_q + TW'(1);
      if (timeout_hit) timeout_q <= 1'b1;
    end
  end

  assign out_timeout = timeout_q;
`else
  assign timeout_hit = 1'b0;
`endif

  assign out_motion_update_enable = enable_q;
  assign out_busy                 = busy_q;
  assign out_done                 = done_q;
  assign out_beat_count           = beat_count_q;
  assign out_data                 = data_p1;
  assign out_data_dst_cell        = dst_p1;
  assign out_data_valid           = vld_p1;

endmodule

// File: tb/tb_motion_update_broadcast_arbiter.sv
// Bench for motion_update_broadcast_arbiter: directed passes with a queue scoreboard on broadcast beats.
module tb_motion_update_broadcast_arbiter;
  localparam int DATA_WIDTH = 32, CELL_ID_WIDTH = 4, NUM_REQ = 4;
  localparam int GUARD_CYCLES = 3, COUNT_WIDTH = 16, TIMEOUT_CYCLES = 8;
  localparam int BW = 3 * DATA_WIDTH, CW = 3 * CELL_ID_WIDTH;

  logic clk = 1'b0;
  logic rst, in_start;
  logic [NUM_REQ-1:0]         in_req_valid, in_req_done, out_req_ready;
  logic [NUM_REQ*BW-1:0]      in_req_data;
  logic [NUM_REQ*CW-1:0]      in_req_dst_cell;
  logic                       out_motion_update_enable, out_data_valid, out_busy, out_done;
  logic [BW-1:0]              out_data;
  logic [CW-1:0]              out_data_dst_cell;
  logic [COUNT_WIDTH-1:0]     out_beat_count;
`ifdef MU_ARB_TIMEOUT_EN
  logic                       out_timeout;
`endif

  motion_update_broadcast_arbiter #(
    .DATA_WIDTH(DATA_WIDTH), .CELL_ID_WIDTH(CELL_ID_WIDTH), .NUM_REQ(NUM_REQ),
    .GUARD_CYCLES(GUARD_CYCLES), .COUNT_WIDTH(COUNT_WIDTH), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .clk(clk), .rst(rst), .in_start(in_start),
    .in_req_valid(in_req_valid), .in_req_data(in_req_data),
    .in_req_dst_cell(in_req_dst_cell), .in_req_done(in_req_done),
    .out_req_ready(out_req_ready), .out_motion_update_enable(out_motion_update_enable),
    .out_data(out_data), .out_data_dst_cell(out_data_dst_cell),
    .out_data_valid(out_data_valid), .out_busy(out_busy), .out_done(out_done),
    .out_beat_count(out_beat_count)
`ifdef MU_ARB_TIMEOUT_EN
    , .out_timeout(out_timeout)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  logic mon_en = 1'b0;
  logic [BW+CW-1:0] exp_q[$];
  int rem[NUM_REQ];
  int nxt[NUM_REQ];
  logic [NUM_REQ-1:0] hold_done_lo = '0;
  logic tr_en[256];
  logic tr_vld[256];
  int   tr_bc[256];

  function automatic logic [BW-1:0] beat_data(input int i, input int b);
    return {DATA_WIDTH'(i*256 + b*4 + 2), DATA_WIDTH'(i*256 + b*4 + 1), DATA_WIDTH'(i*256 + b*4)};
  endfunction

  function automatic logic [CW-1:0] beat_dst(input int i, input int b);
    return {CELL_ID_WIDTH'(i), CELL_ID_WIDTH'(b), CELL_ID_WIDTH'(i + b + 1)};
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_beat(input int i, input int b);
    exp_q.push_back({beat_data(i, b), beat_dst(i, b)});
  endtask

  task automatic drive_reqs();
    for (int i = 0; i < NUM_REQ; i++) begin
      in_req_valid[i] = (rem[i] > 0);
      in_req_done[i]  = (rem[i] <= 1) && !hold_done_lo[i];
      in_req_data[i*BW +: BW]     = beat_data(i, nxt[i]);
      in_req_dst_cell[i*CW +: CW] = beat_dst(i, nxt[i]);
    end
  endtask

  task automatic set_reqs(input int r0, input int r1, input int r2, input int r3);
    rem[0] = r0; rem[1] = r1; rem[2] = r2; rem[3] = r3;
    for (int i = 0; i < NUM_REQ; i++) nxt[i] = 0;
    drive_reqs();
  endtask

  // Broadcast scoreboard and grant legality.
  always @(negedge clk) begin
    if (mon_en) begin
      if (out_data_valid) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_beat: got %0h expected no beat", {out_data, out_data_dst_cell});
        end else begin
          check("beat", {out_data, out_data_dst_cell}, exp_q.pop_front());
        end
        check("enable_with_beat", out_motion_update_enable, 1'b1);
      end else begin
        check("idle_bus_zero", {out_data, out_data_dst_cell}, '0);
      end
      if (out_req_ready != '0) begin
        check("grant_onehot", $onehot(out_req_ready), 1'b1);
        check("grant_only_valid", out_req_ready & ~in_req_valid, '0);
      end
    end
  end

  // Pulses in_start (starting at posedge+1), then walks the pass cycle by cycle.
  task automatic run_pass(input int pulse_at, input int rst_at, input int max_cyc, output int done_idx);
    logic prev_hs, prev_rst;
    logic [NUM_REQ-1:0] hs;
    done_idx = -1; prev_hs = 1'b0; prev_rst = 1'b0;
    in_start = 1'b1;
    @(posedge clk); #1;
    in_start = 1'b0;
    for (int c = 0; c < max_cyc; c++) begin
      @(negedge clk);
      tr_en[c]  = out_motion_update_enable;
      tr_vld[c] = out_data_valid;
      tr_bc[c]  = int'(out_beat_count);
      check("beat_latency", out_data_valid, prev_hs && !prev_rst);
      if (c == 0) check("count_cleared_at_start", out_beat_count, '0);
      hs = out_req_ready & in_req_valid;
      prev_hs = |hs; prev_rst = rst;
      if (out_done) begin
        done_idx = c;
        check("busy_at_done", out_busy, 1'b1);
        break;
      end
      @(posedge clk); #1;
      for (int i = 0; i < NUM_REQ; i++) if (hs[i]) begin rem[i]--; nxt[i]++; end
      drive_reqs();
      in_start = (c + 1 == pulse_at);
      rst      = (c + 1 == rst_at);
    end
    @(posedge clk); #1;
    in_start = 1'b0; rst = 1'b0;
  endtask

  // Enable window: BROADCAST..DRAIN high, GUARD low, DONE at done_idx.
  task automatic check_tail(input int done_idx, input int exp_done, input int exp_beats);
    int nv;
    nv = 0;
    check("done_cycle", done_idx, exp_done);
    if (done_idx >= 4) begin
      for (int c = 0; c <= done_idx; c++) begin
        check("enable_window", tr_en[c], (c <= done_idx - 4));
        if (tr_vld[c]) nv++;
      end
      check("drain_no_beat", tr_vld[done_idx-4], 1'b0);
      check("beats_in_pass", nv, exp_beats);
      check("beat_count_at_done", tr_bc[done_idx], exp_beats);
    end
    check("scoreboard_drained", exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int d;
    rst = 1'b1; in_start = 1'b0;
    set_reqs(0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    in_req_valid = 4'b1111;
    @(negedge clk);
    check("rst_ready", out_req_ready, '0);
    check("rst_enable", out_motion_update_enable, 1'b0);
    check("rst_valid", out_data_valid, 1'b0);
    check("rst_busy", out_busy, 1'b0);
    check("rst_done", out_done, 1'b0);
    check("rst_data", {out_data, out_data_dst_cell}, '0);
    check("rst_count", out_beat_count, '0);
    @(posedge clk); #1;
    rst = 1'b0;
    set_reqs(0, 0, 0, 0);
    mon_en = 1'b1;
    @(posedge clk); #1;

    // Four requesters, three beats each: strict 0,1,2,3 rotation.
    set_reqs(3, 3, 3, 3);
    for (int r = 0; r < 3; r++) for (int i = 0; i < NUM_REQ; i++) push_beat(i, r);
    run_pass(-1, -1, 100, d);
    check_tail(d, 17, 12);

    // All requesters already done: zero-beat pass.
    set_reqs(0, 0, 0, 0);
    run_pass(-1, -1, 100, d);
    check_tail(d, 5, 0);

    // Only requester 2, five beats; in_start pulsed during GUARD must be ignored.
    set_reqs(0, 0, 5, 0);
    for (int b = 0; b < 5; b++) push_beat(2, b);
    run_pass(8, -1, 100, d);
    check_tail(d, 10, 5);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("idle_after_pass_busy", out_busy, 1'b0);
      check("idle_after_pass_enable", out_motion_update_enable, 1'b0);
    end
    @(posedge clk); #1;

    // Pointer sits at 3 after the last pass: requester 3 wins before 0.
    set_reqs(1, 0, 0, 1);
    push_beat(3, 0); push_beat(0, 0);
    run_pass(-1, -1, 100, d);
    check_tail(d, 7, 2);

    // Reset after four beats aborts the pass with no done pulse.
    set_reqs(3, 3, 3, 3);
    push_beat(1, 0); push_beat(2, 0); push_beat(3, 0); push_beat(0, 0);
    run_pass(-1, 4, 25, d);
    check("rst_no_done", d, -1);
    check("rst_count_before", tr_bc[4], 4);
    check("rst_enable_after", tr_en[5], 1'b0);
    check("rst_valid_after", tr_vld[5], 1'b0);
    check("rst_count_after", tr_bc[5], 0);
    check("rst_scoreboard", exp_q.size(), 0);
    set_reqs(0, 0, 0, 0);
    @(posedge clk); #1;

`ifdef MU_ARB_TIMEOUT_EN
    // Requester 1 never signals done: watchdog forces DRAIN 8 cycles after its last beat.
    hold_done_lo = 4'b0010;
    set_reqs(0, 2, 0, 0);
    push_beat(1, 0); push_beat(1, 1);
    run_pass(-1, -1, 100, d);
    check_tail(d, 13, 2);
    check("timeout_flag", out_timeout, 1'b1);
    hold_done_lo = '0;
    set_reqs(0, 0, 0, 0);
`endif

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
